generic_dsp_param: RTL and testbench

Parametrised behavioural model of a cascadable DSP slice for the FIOS Montgomery multiplier datapath. Generalises the fixed 17×17 / 48-bit cascade model:
- operand, C, P, output and shift widths are parameters;
- input register depth is 0–2;
- adds an add/subtract ALU mode, carry-in, a shifted-PCIN Z source, an aligned control/valid pipeline, zero-pattern detect and carry-out.

It sits in each multiplier column. It is chained PCOUT→PCIN and is used in simulation in place of the vendor primitive.

---
 rtl/generic_dsp_param_if.sv | 34 +++
 rtl/generic_dsp_param.sv | 152 +++++++++++++++
 tb/tb_generic_dsp_param.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/generic_dsp_param_if.sv
// Signal bundle for one DSP slice: operands, control, cascade input and result flags.
// master drives the operation, slave is the slice itself.
interface generic_dsp_param_if #(
    parameter int unsigned AW  = 17,
    parameter int unsigned BW  = 17,
    parameter int unsigned CW  = 34,
    parameter int unsigned PW  = 48,
    parameter int unsigned POW = 34
);
    logic            valid_i;
    logic            CREG_en_i;
    logic [8:0]      OPMODE_i;
    logic            ALUMODE_i;
    logic            CARRYIN_i;
    logic [AW-1:0]   A_i;
    logic [BW-1:0]   B_i;
    logic [CW-1:0]   C_i;
    logic [PW-1:0]   PCIN_i;
    logic [POW-1:0]  P_o;
    logic [PW-1:0]   PCOUT_o;
    logic            valid_o;
    logic            pdet_o;
    logic            carry_o;

    modport master (
        output valid_i, CREG_en_i, OPMODE_i, ALUMODE_i, CARRYIN_i, A_i, B_i, C_i, PCIN_i,
        input  P_o, PCOUT_o, valid_o, pdet_o, carry_o
    );

    modport slave (
        input  valid_i, CREG_en_i, OPMODE_i, ALUMODE_i, CARRYIN_i, A_i, B_i, C_i, PCIN_i,
        output P_o, PCOUT_o, valid_o, pdet_o, carry_o
    );
endinterface

// File: rtl/generic_dsp_param.sv
// Parametrised cascadable DSP slice: optional A/B/M/C registers, W/XY/Z operand muxes,
// add/subtract ALU with carry-in, P register with zero-pattern detect and carry-out.
module generic_dsp_param #(
    parameter int unsigned AW    = 17,
    parameter int unsigned BW    = 17,
    parameter int unsigned CW    = 34,
    parameter int unsigned PW    = 48,
    parameter int unsigned POW   = 34,
    parameter int unsigned SHIFT = 17,
    parameter int unsigned ABREG = 1,
    parameter int unsigned MREG  = 1,
    parameter int unsigned CREG  = 1
) (
    input logic                clock_i,
    input logic                reset_i,
    generic_dsp_param_if.slave bus
);
    typedef struct packed {
        logic       valid;
        logic [8:0] opmode;
        logic       alumode;
        logic       carryin;
    } ctl_t;

    localparam int unsigned CtlDepth = ABREG + MREG;

    ctl_t             ctl_in;
    ctl_t             ctl_s;
    logic [AW-1:0]    a_s;
    logic [BW-1:0]    b_s;
    logic [AW+BW-1:0] m_prod;
    logic [AW+BW-1:0] m_s;
    logic [CW-1:0]    c_s;
    logic [PW-1:0]    w_val;
    logic [PW-1:0]    xy_val;
    logic [PW-1:0]    z_val;
    logic [PW:0]      rhs;
    logic [PW:0]      sum;
    logic [PW-1:0]    p_q;
    logic             valid_q;
    logic             pdet_q;
    logic             carry_q;

    assign ctl_in = {bus.valid_i, bus.OPMODE_i, bus.ALUMODE_i, bus.CARRYIN_i};

    if (ABREG == 0) begin : g_ab_pass
        assign a_s = bus.A_i;
        assign b_s = bus.B_i;
    end else begin : g_ab_reg
        logic [AW-1:0] a_q [ABREG];
        logic [BW-1:0] b_q [ABREG];
        // A/B operand register chain of ABREG stages.
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                for (int i = 0; i < ABREG; i++) begin
                    a_q[i] <= '0;
                    b_q[i] <= '0;
                end
            end else begin
                a_q[0] <= bus.A_i;
                b_q[0] <= bus.B_i;
                for (int i = 1; i < ABREG; i++) begin
                    a_q[i] <= a_q[i-1];
                    b_q[i] <= b_q[i-1];
                end
            end
        end
        assign a_s = a_q[ABREG-1];
        assign b_s = b_q[ABREG-1];
    end

    assign m_prod = {{BW{1'b0}}, a_s} * {{AW{1'b0}}, b_s};

    if (MREG == 0) begin : g_m_pass
        assign m_s = m_prod;
    end else begin : g_m_reg
        logic [AW+BW-1:0] m_q;
        // Product register.
        always_ff @(posedge clock_i) begin
            if (reset_i) m_q <= '0;
            else         m_q <= m_prod;
        end
        assign m_s = m_q;
    end

    if (CtlDepth == 0) begin : g_ctl_pass
        assign ctl_s = ctl_in;
    end else begin : g_ctl_pipe
        ctl_t ctl_q [CtlDepth];
        // Delay control by the A/B+M depth so it meets its own product at the adder.
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                for (int i = 0; i < CtlDepth; i++) ctl_q[i] <= '0;
            end else begin
                ctl_q[0] <= ctl_in;
                for (int i = 1; i < CtlDepth; i++) ctl_q[i] <= ctl_q[i-1];
            end
        end
        assign ctl_s = ctl_q[CtlDepth-1];
    end

    if (CREG == 0) begin : g_c_pass
        assign c_s = bus.C_i;
    end else begin : g_c_reg
        logic [CW-1:0] c_q;
        // C holding register; not aligned with A/B, reset beats the load enable.
        always_ff @(posedge clock_i) begin
            if (reset_i)            c_q <= '0;
            else if (bus.CREG_en_i) c_q <= bus.C_i;
        end
        assign c_s = c_q;
    end

    // Operand muxes and the PW+1 bit add/subtract; bit PW is carry or borrow.
    always_comb begin
        w_val  = '0;
        xy_val = '0;
        z_val  = '0;
        if (ctl_s.opmode[8:7] == 2'b11) w_val = PW'(c_s);
        if (ctl_s.opmode[3:0] == 4'b0101) xy_val = PW'(m_s);
        case (ctl_s.opmode[6:4])
            3'b010:  z_val = p_q;
            3'b110:  z_val = p_q >> SHIFT;
            3'b001:  z_val = bus.PCIN_i;
            3'b101:  z_val = bus.PCIN_i >> SHIFT;
            default: z_val = '0;
        endcase
        rhs = {1'b0, w_val} + {1'b0, xy_val} + {{PW{1'b0}}, ctl_s.carryin};
        sum = ctl_s.alumode ? ({1'b0, z_val} - rhs) : ({1'b0, z_val} + rhs);
    end

    // P register and result flags; P updates every cycle, valid only qualifies it.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            p_q     <= '0;
            valid_q <= 1'b0;
            pdet_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            p_q     <= sum[PW-1:0];
            valid_q <= ctl_s.valid;
            pdet_q  <= (sum[POW-1:0] == '0);
            carry_q <= sum[PW];
        end
    end

    assign bus.P_o     = p_q[POW-1:0];
    assign bus.PCOUT_o = p_q;
    assign bus.valid_o = valid_q;
    assign bus.pdet_o  = pdet_q;
    assign bus.carry_o = carry_q;
endmodule

// File: tb/tb_generic_dsp_param.sv
// Bench for generic_dsp_param: directed scenarios, latency sweep over register depths,
// cascade of two slices, reset behaviour, and a randomized run against an arithmetic model.
module tb_generic_dsp_param;
    localparam int unsigned SH = 17;

    typedef struct packed {
        logic        v;
        logic [8:0]  opm;
        logic        alu;
        logic        cin;
        logic [16:0] a;
        logic [16:0] b;
    } op_t;

    logic clock = 1'b0;
    logic reset;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clock = ~clock;

    generic_dsp_param_if bus_a ();
    generic_dsp_param_if bus_b ();
    generic_dsp_param_if bus_p00 ();
    generic_dsp_param_if bus_p20 ();
    generic_dsp_param_if bus_p21 ();

    generic_dsp_param u_a (.clock_i(clock), .reset_i(reset), .bus(bus_a));
    generic_dsp_param u_b (.clock_i(clock), .reset_i(reset), .bus(bus_b));
    generic_dsp_param #(.ABREG(0), .MREG(0)) u_p00 (.clock_i(clock), .reset_i(reset), .bus(bus_p00));
    generic_dsp_param #(.ABREG(2), .MREG(0)) u_p20 (.clock_i(clock), .reset_i(reset), .bus(bus_p20));
    generic_dsp_param #(.ABREG(2), .MREG(1)) u_p21 (.clock_i(clock), .reset_i(reset), .bus(bus_p21));

    assign bus_b.PCIN_i = bus_a.PCOUT_o;

    assign bus_p00.valid_i = bus_a.valid_i;     assign bus_p00.CREG_en_i = bus_a.CREG_en_i;
    assign bus_p00.OPMODE_i = bus_a.OPMODE_i;   assign bus_p00.ALUMODE_i = bus_a.ALUMODE_i;
    assign bus_p00.CARRYIN_i = bus_a.CARRYIN_i; assign bus_p00.A_i = bus_a.A_i;
    assign bus_p00.B_i = bus_a.B_i;             assign bus_p00.C_i = bus_a.C_i;
    assign bus_p00.PCIN_i = bus_a.PCIN_i;
    assign bus_p20.valid_i = bus_a.valid_i;     assign bus_p20.CREG_en_i = bus_a.CREG_en_i;
    assign bus_p20.OPMODE_i = bus_a.OPMODE_i;   assign bus_p20.ALUMODE_i = bus_a.ALUMODE_i;
    assign bus_p20.CARRYIN_i = bus_a.CARRYIN_i; assign bus_p20.A_i = bus_a.A_i;
    assign bus_p20.B_i = bus_a.B_i;             assign bus_p20.C_i = bus_a.C_i;
    assign bus_p20.PCIN_i = bus_a.PCIN_i;
    assign bus_p21.valid_i = bus_a.valid_i;     assign bus_p21.CREG_en_i = bus_a.CREG_en_i;
    assign bus_p21.OPMODE_i = bus_a.OPMODE_i;   assign bus_p21.ALUMODE_i = bus_a.ALUMODE_i;
    assign bus_p21.CARRYIN_i = bus_a.CARRYIN_i; assign bus_p21.A_i = bus_a.A_i;
    assign bus_p21.B_i = bus_a.B_i;             assign bus_p21.C_i = bus_a.C_i;
    assign bus_p21.PCIN_i = bus_a.PCIN_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input logic [16:0] a, input logic [16:0] b, input logic [8:0] opm,
                         input logic alu, input logic cin, input logic v);
        bus_a.A_i       = a;
        bus_a.B_i       = b;
        bus_a.OPMODE_i  = opm;
        bus_a.ALUMODE_i = alu;
        bus_a.CARRYIN_i = cin;
        bus_a.valid_i   = v;
    endtask

    // Full PW+1 bit result of one operation, from the operand-selection rules.
    function automatic logic [48:0] model_sum(input op_t o, input logic [47:0] p,
                                              input logic [47:0] c, input logic [47:0] pcin);
        longint unsigned z, w, xy, rhs;
        case (o.opm[6:4])
            3'b010:  z = 64'(p);
            3'b110:  z = 64'(p) >> SH;
            3'b001:  z = 64'(pcin);
            3'b101:  z = 64'(pcin) >> SH;
            default: z = 64'd0;
        endcase
        w   = (o.opm[8:7] == 2'b11) ? 64'(c) : 64'd0;
        xy  = (o.opm[3:0] == 4'b0101) ? 64'(o.a) * 64'(o.b) : 64'd0;
        rhs = w + xy + 64'(o.cin);
        return o.alu ? 49'(z - rhs) : 49'(z + rhs);
    endfunction

    initial begin
        op_t             pend[$];
        op_t             cur;
        op_t             fut;
        logic [47:0]     m_p;
        logic [47:0]     m_c;
        logic [48:0]     s;
        logic [3:0]      xy_sel;

        reset = 1'b1;
        set_a(0, 0, 9'd0, 1'b0, 1'b0, 1'b0);
        bus_a.C_i = '0;  bus_a.CREG_en_i = 1'b0; bus_a.PCIN_i = '0;
        bus_b.A_i = '0;  bus_b.B_i = '0; bus_b.OPMODE_i = '0; bus_b.ALUMODE_i = 1'b0;
        bus_b.CARRYIN_i = 1'b0; bus_b.valid_i = 1'b0; bus_b.C_i = '0; bus_b.CREG_en_i = 1'b0;
        repeat (3) tick();
        check("rst_p", 64'(bus_a.P_o), 64'd0);
        check("rst_pcout", 64'(bus_a.PCOUT_o), 64'd0);
        check("rst_valid", 64'(bus_a.valid_o), 64'd0);
        check("rst_carry", 64'(bus_a.carry_o), 64'd0);
        check("rst_pdet", 64'(bus_a.pdet_o), 64'd0);
        reset = 1'b0;

        // Basic multiply, observed on all register-depth variants.
        set_a(3, 5, 9'b00_000_0101, 1'b0, 1'b0, 1'b1);
        tick();
        set_a(0, 0, 9'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("lat_def_valid", 64'(bus_a.valid_o), 64'(k == 2));
            check("lat_def_p", 64'(bus_a.P_o), 64'((k == 2) ? 15 : 0));
            check("lat_00_valid", 64'(bus_p00.valid_o), 64'(k == 0));
            check("lat_00_p", 64'(bus_p00.P_o), 64'((k == 0) ? 15 : 0));
            check("lat_20_valid", 64'(bus_p20.valid_o), 64'(k == 2));
            check("lat_21_valid", 64'(bus_p21.valid_o), 64'(k == 3));
            check("lat_21_p", 64'(bus_p21.P_o), 64'((k == 3) ? 15 : 0));
            if (k == 2) begin
                check("mul_pdet", 64'(bus_a.pdet_o), 64'd0);
                check("mul_carry", 64'(bus_a.carry_o), 64'd0);
            end
            tick();
        end

        // Shift-accumulate: load P from C, then P>>SHIFT plus 1*1.
        bus_a.C_i = 34'h60000; bus_a.CREG_en_i = 1'b1;
        set_a(0, 0, 9'b11_000_0000, 1'b0, 1'b0, 1'b1);
        tick();
        bus_a.CREG_en_i = 1'b0;
        set_a(1, 1, 9'b00_110_0101, 1'b0, 1'b0, 1'b1);
        tick();
        set_a(0, 0, 9'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("shacc_load", 64'(bus_a.PCOUT_o), 64'h60000);
        tick();
        check("shacc", 64'(bus_a.PCOUT_o), 64'd4);

        // Subtract with C: 0 - (100 + 2*3) borrows.
        bus_a.C_i = 34'd100; bus_a.CREG_en_i = 1'b1;
        set_a(2, 3, 9'b11_000_0101, 1'b1, 1'b0, 1'b1);
        tick();
        bus_a.CREG_en_i = 1'b0;
        set_a(0, 0, 9'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("sub_pcout", 64'(bus_a.PCOUT_o), 64'(48'hFFFF_FFFF_FF96));
        check("sub_p", 64'(bus_a.P_o), 64'(34'h3_FFFF_FF96));
        check("sub_carry", 64'(bus_a.carry_o), 64'd1);
        check("sub_pdet", 64'(bus_a.pdet_o), 64'd0);

        // Pattern detect: P=20, then P - 4*5.
        set_a(4, 5, 9'b00_000_0101, 1'b0, 1'b0, 1'b1);
        tick();
        set_a(4, 5, 9'b00_010_0101, 1'b1, 1'b0, 1'b1);
        tick();
        set_a(0, 0, 9'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("pat_pre", 64'(bus_a.P_o), 64'd20);
        tick();
        check("pat_p", 64'(bus_a.P_o), 64'd0);
        check("pat_pdet", 64'(bus_a.pdet_o), 64'd1);
        check("pat_carry", 64'(bus_a.carry_o), 64'd0);

        // Cascade: slice B adds PCIN (=63 from slice A) to 1*1, one cycle later.
        set_a(7, 9, 9'b00_000_0101, 1'b0, 1'b0, 1'b1);
        tick();
        set_a(0, 0, 9'd0, 1'b0, 1'b0, 1'b0);
        bus_b.A_i = 1; bus_b.B_i = 1; bus_b.OPMODE_i = 9'b00_001_0101; bus_b.valid_i = 1'b1;
        tick();
        bus_b.A_i = 0; bus_b.B_i = 0; bus_b.OPMODE_i = 9'd0; bus_b.valid_i = 1'b0;
        tick();
        check("casc_a", 64'(bus_a.PCOUT_o), 64'd63);
        tick();
        check("casc_b", 64'(bus_b.PCOUT_o), 64'd64);
        check("casc_b_valid", 64'(bus_b.valid_o), 64'd1);

        // Reset with an operation in flight; C load during reset must lose.
        set_a(0, 0, 9'b11_000_0000, 1'b0, 1'b0, 1'b1);
        tick();
        set_a(0, 0, 9'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_a(3, 5, 9'b00_000_0101, 1'b0, 1'b0, 1'b1);
        tick();
        check("pre_reset_p", 64'(bus_a.PCOUT_o), 64'd100);
        set_a(0, 0, 9'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1; bus_a.C_i = 34'd5; bus_a.CREG_en_i = 1'b1;
        tick();
        check("reset_p", 64'(bus_a.P_o), 64'd0);
        check("reset_pcout", 64'(bus_a.PCOUT_o), 64'd0);
        check("reset_valid", 64'(bus_a.valid_o), 64'd0);
        reset = 1'b0; bus_a.CREG_en_i = 1'b0; bus_a.C_i = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("reset_no_valid", 64'(bus_a.valid_o), 64'd0);
        end
        set_a(0, 0, 9'b11_000_0000, 1'b0, 1'b0, 1'b1);
        tick();
        set_a(0, 0, 9'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check("c_reset_wins", 64'(bus_a.PCOUT_o), 64'd0);
        check("post_reset_valid", 64'(bus_a.valid_o), 64'd1);

        // Randomized run against the model, from a clean reset.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_p = '0;
        m_c = '0;
        pend.push_back('0);
        pend.push_back('0);
        for (int n = 0; n < 300; n++) begin
            fut.v   = 1'($urandom_range(0, 1));
            fut.alu = 1'($urandom_range(0, 1));
            fut.cin = 1'($urandom_range(0, 1));
            fut.a   = 17'($urandom);
            fut.b   = 17'($urandom);
            xy_sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) :
                      ($urandom_range(0, 3) != 0) ? 4'b0101 : 4'b0000;
            fut.opm = {2'($urandom), 3'($urandom), xy_sel};
            set_a(fut.a, fut.b, fut.opm, fut.alu, fut.cin, fut.v);
            bus_a.C_i       = 34'($urandom_range(0, 7) == 0 ? 0 : {$urandom, $urandom});
            bus_a.CREG_en_i = 1'($urandom_range(0, 1));
            bus_a.PCIN_i    = 48'({$urandom, $urandom});
            pend.push_back(fut);
            cur = pend.pop_front();
            s   = model_sum(cur, m_p, m_c, bus_a.PCIN_i);
            if (bus_a.CREG_en_i) m_c = 48'(bus_a.C_i);
            tick();
            m_p = s[47:0];
            check("rnd_pcout", 64'(bus_a.PCOUT_o), 64'(s[47:0]));
            check("rnd_p", 64'(bus_a.P_o), 64'(s[33:0]));
            check("rnd_carry", 64'(bus_a.carry_o), 64'(s[48]));
            check("rnd_pdet", 64'(bus_a.pdet_o), 64'(s[33:0] == 34'd0));
            check("rnd_valid", 64'(bus_a.valid_o), 64'(cur.v));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
